// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per cycle, subkeys K16..K1 derived on the fly.
// Optional key parity flag (key_err) is built only when DES_DEC_PARITY_CHK_EN is defined.
module des_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] din,
  input  logic [1:64] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] dout
`ifdef DES_DEC_PARITY_CHK_EN
  ,
  output logic        key_err
`endif
);

  // Tables use DES numbering: entry n names input bit n, bit 1 being the MSB.
  localparam int unsigned IpTab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FpTab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam int unsigned ETab [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31,
    32, 1};

  localparam int unsigned PTab [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
    29, 32};

  // 64 x 4-bit entries, entry 0 at the MSB, index = {row, column}.
  localparam logic [255:0] SBox [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - IpTab[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - FpTab[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47 - i] = x[32 - ETab[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31 - i] = x[32 - PTab[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55 - i] = x[64 - Pc1Tab[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47 - i] = x[56 - Pc2Tab[i]];
    return y;
  endfunction

  function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl, input logic [5:0] b);
    logic [5:0]   idx;
    logic [255:0] sh;
    idx = {b[5], b[0], b[4:1]};
    sh  = tbl >> {(6'd63 - idx), 2'b00};
    return sh[3:0];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = e_perm(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) s[31 - 4 * i -: 4] = sbox_lookup(SBox[i], x[47 - 6 * i -: 6]);
    return p_perm(s);
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd0:    return x;
      2'd1:    return {x[0], x[27:1]};
      default: return {x[1:0], x[27:2]};
    endcase
  endfunction

  typedef enum logic [1:0] {StIdle, StRound, StOut} state_e;

  state_e      state_q;
  logic [4:0]  rnd_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [63:0] dout_q;
  logic        out_valid_q;

  logic [63:0] din_v, key_v, ip_blk;
  logic [55:0] pc1_key;
  logic [1:0]  shamt;
  logic [27:0] c_d, d_d;
  logic [47:0] subkey;
  logic [31:0] f_out;

  assign din_v   = din;
  assign key_v   = key;
  assign ip_blk  = ip_perm(din_v);
  assign pc1_key = pc1_perm(key_v);

  // Right-rotation schedule that walks the encryption subkeys backwards.
  always_comb begin
    case (rnd_q)
      5'd1:                   shamt = 2'd0;
      5'd2, 5'd9, 5'd16:      shamt = 2'd1;
      default:                shamt = 2'd2;
    endcase
    c_d    = rotr28(c_q, shamt);
    d_d    = rotr28(d_q, shamt);
    subkey = pc2_perm({c_d, d_d});
    f_out  = feistel(r_q, subkey);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rnd_q       <= 5'd0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            l_q     <= ip_blk[63:32];
            r_q     <= ip_blk[31:0];
            c_q     <= pc1_key[55:28];
            d_q     <= pc1_key[27:0];
            rnd_q   <= 5'd1;
            state_q <= StRound;
          end
        end
        StRound: begin
          if (rnd_q == 5'd16) begin
            // Preoutput is R16L16: the last round skips the half swap.
            dout_q      <= fp_perm({l_q ^ f_out, r_q});
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            l_q   <= r_q;
            r_q   <= l_q ^ f_out;
            c_q   <= c_d;
            d_q   <= d_d;
            rnd_q <= rnd_q + 5'd1;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rnd_q       <= 5'd0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

`ifdef DES_DEC_PARITY_CHK_EN
  logic key_even;
  logic key_err_q;

  // Every key byte must carry odd parity.
  always_comb begin
    key_even = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (^key_v[63 - 8 * i -: 8] == 1'b0) key_even = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_err_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      key_err_q <= key_even;
    end else if (out_valid_q && out_ready) begin
      key_err_q <= 1'b0;
    end
  end

  assign key_err = key_err_q;
`endif

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core using published DES known-answer vectors.
module tb_des_decrypt_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] din;
  logic [1:64] key;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] dout;
`ifdef DES_DEC_PARITY_CHK_EN
  logic        key_err;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q [$];

  des_decrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef DES_DEC_PARITY_CHK_EN
    ,
    .key_err   (key_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic send(input logic [63:0] ct, input logic [63:0] k, input logic [63:0] exp);
    wait_idle();
    din      = ct;
    key      = k;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  // Monitor: a handshake is seen on the falling edge before the completing rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h, want none", dout);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    key       = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_dout", dout, 64'h0);
`ifdef DES_DEC_PARITY_CHK_EN
    check("rst_key_err", {63'd0, key_err}, 64'd0);
`endif

    // Known answer 1 with latency measurement.
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
    check("busy_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef DES_DEC_PARITY_CHK_EN
    check("ka1_key_err", {63'd0, key_err}, 64'd0);
`endif
    wait_valid(lat);
    check("latency", 64'(lat), 64'd16);
    wait_idle();

    // Known answer 2.
    send(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787);
    wait_valid(lat);
    wait_idle();

    // Backpressure then back-to-back block.
    out_ready = 1'b0;
    send(64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_dout", dout, 64'h8CA64DE9C1B123A7);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
    send(64'h8CA64DE9C1B123A7, 64'h0000000000000000, 64'h0000000000000000);
    wait_valid(lat);
    wait_idle();

    // Garbage on in_valid while rounds run.
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      din      = {$urandom, $urandom};
      key      = {$urandom, $urandom};
      check("garbage_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_valid(lat);
    wait_idle();

    // Reset in round 8 discards the block.
    send(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_dout", dout, 64'h0);
    send(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58);
    wait_valid(lat);
    wait_idle();
    send(64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    wait_valid(lat);
    wait_idle();
    send(64'h3FA40E8A984D4815, 64'h0123456789ABCDEF, 64'h4E6F772069732074);
    wait_valid(lat);
    wait_idle();

`ifdef DES_DEC_PARITY_CHK_EN
    out_ready = 1'b0;
    send(64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7);
    check("par_round_key_err", {63'd0, key_err}, 64'd1);
    wait_valid(lat);
    check("par_out_key_err", {63'd0, key_err}, 64'd1);
    out_ready = 1'b1;
    wait_idle();
    check("par_idle_key_err", {63'd0, key_err}, 64'd0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
